// File: rtl/dpsram_pkg.sv
// dpsram_pkg -- shared types and constants for the dual-port SRAM.
//
// Contents:
//   state_t  : controller state (ST_INIT clears the array, ST_IDLE serves ports)
//   RD_LAT   : read latency in cycles from request to o_rvalid/o_data
//
// Build option: define DPSRAM_OREG_EN to add an output register stage on
// each port (read latency 2 instead of 1).
package dpsram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

`ifdef DPSRAM_OREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

endpackage

// File: rtl/dpsram_port.sv
// dpsram_port -- read pipeline for one SRAM port.
//
// Registers the word presented on rd_word when rd_en is high and raises
// rvalid for exactly one cycle per accepted read. The data register only
// loads on a read, so data holds the last read value between reads.
// With DPSRAM_OREG_EN defined a second register stage is added and rvalid
// is delayed alongside it.
//
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset (clears data and rvalid)
//   rd_en   : accepted read request this cycle
//   rd_word : array word at the requested address (pre-write value)
//   data    : read data output
//   rvalid  : one-cycle pulse marking new read data
module dpsram_port
  import dpsram_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic [DW-1:0] rd_word,
  output logic [DW-1:0] data,
  output logic          rvalid
);

  logic [DW-1:0] s1_data;
  logic          s1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_en;
      if (rd_en) s1_data <= rd_word;
    end
  end

`ifdef DPSRAM_OREG_EN
  logic [DW-1:0] s2_data;
  logic          s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_data  <= '0;
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= s1_data;
    end
  end

  assign data   = s2_data;
  assign rvalid = s2_valid;
`else
  assign data   = s1_data;
  assign rvalid = s1_valid;
`endif

endmodule

// File: rtl/dpsram.sv
// dpsram -- true dual-port SRAM with byte enables and self-clearing init.
//
// After reset the controller writes zero to every word, one per cycle,
// then raises o_ready. Port accesses are ignored until o_ready is high.
// Reads are read-first: a read of a word written in the same cycle (by
// either port) returns the old contents. When both ports write the same
// word, port A wins on bytes it enables; port B fills bytes only it enables.
//
// Parameters: DW data width (multiple of 8), AW address width (2**AW words).
// Build option: DPSRAM_OREG_EN adds an output register stage (latency 2).
//
// Ports:
//   i_clk, i_rst                 : clock, async active-high reset
//   i_csn_x  (x = a|b)           : chip select, active low
//   i_wr_x                       : 1 = write, 0 = read
//   i_be_x   [DW/8]              : byte write enables
//   i_addr_x [AW]                : word address
//   i_data_x [DW]                : write data
//   o_data_x [DW]                : read data (holds last read)
//   o_rvalid_x                   : read data valid pulse
//   o_ready                      : init complete, accesses accepted
//   dbg_state                    : controller state for observation
module dpsram
  import dpsram_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_csn_a,
  input  logic            i_csn_b,
  input  logic            i_wr_a,
  input  logic            i_wr_b,
  input  logic [DW/8-1:0] i_be_a,
  input  logic [DW/8-1:0] i_be_b,
  input  logic [AW-1:0]   i_addr_a,
  input  logic [AW-1:0]   i_addr_b,
  input  logic [DW-1:0]   i_data_a,
  input  logic [DW-1:0]   i_data_b,
  output logic [DW-1:0]   o_data_a,
  output logic [DW-1:0]   o_data_b,
  output logic            o_rvalid_a,
  output logic            o_rvalid_b,
  output logic            o_ready,
  output state_t          dbg_state
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  state_t        state;
  logic [AW-1:0] init_cnt;
  logic          ready;

  // Controller: walk init_cnt over the whole array, then sit in IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == AW'(DEPTH - 1)) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          ready <= 1'b1;
        end
        default: begin
          state <= ST_INIT;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready   = ready;
  assign dbg_state = state;

  logic wr_en_a, wr_en_b, rd_en_a, rd_en_b;

  assign wr_en_a = ready & ~i_csn_a & i_wr_a;
  assign wr_en_b = ready & ~i_csn_b & i_wr_b;
  assign rd_en_a = ready & ~i_csn_a & ~i_wr_a;
  assign rd_en_b = ready & ~i_csn_b & ~i_wr_b;

  // Storage has no reset; it is cleared only by the init walk.
  logic [DW-1:0] mem [DEPTH];

  // Port B bytes are assigned first so that port A's later non-blocking
  // assignment takes precedence on bytes both ports enable.
  always_ff @(posedge i_clk) begin
    if (!ready) begin
      mem[init_cnt] <= '0;
    end else begin
      for (int n = 0; n < NB; n++) begin
        if (wr_en_b && i_be_b[n]) mem[i_addr_b][8*n +: 8] <= i_data_b[8*n +: 8];
      end
      for (int n = 0; n < NB; n++) begin
        if (wr_en_a && i_be_a[n]) mem[i_addr_a][8*n +: 8] <= i_data_a[8*n +: 8];
      end
    end
  end

  // Combinational array read sampled by the port pipeline gives the
  // pre-write contents, which is what read-first requires.
  logic [DW-1:0] rd_word_a, rd_word_b;

  assign rd_word_a = mem[i_addr_a];
  assign rd_word_b = mem[i_addr_b];

  dpsram_port #(.DW(DW)) u_port_a (
    .clk     (i_clk),
    .rst     (i_rst),
    .rd_en   (rd_en_a),
    .rd_word (rd_word_a),
    .data    (o_data_a),
    .rvalid  (o_rvalid_a)
  );

  dpsram_port #(.DW(DW)) u_port_b (
    .clk     (i_clk),
    .rst     (i_rst),
    .rd_en   (rd_en_b),
    .rd_word (rd_word_b),
    .data    (o_data_b),
    .rvalid  (o_rvalid_b)
  );

endmodule

// File: tb/tb_dpsram.sv
// tb_dpsram -- self-checking bench for dpsram (DW=32, AW=4).
//
// Handshake: a port read is accepted when o_ready=1 and csn=0 at a rising
// edge; its data appears with a one-cycle o_rvalid pulse LAT edges later.
// Writes never pulse o_rvalid.
module tb_dpsram;
  import dpsram_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef DPSRAM_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk, rst;
  logic          csn_a, csn_b, wr_a, wr_b;
  logic [3:0]    be_a, be_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          rvalid_a, rvalid_b, ready;
  state_t        dbg_state;

  dpsram #(.DW(DW), .AW(AW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_csn_a    (csn_a),
    .i_csn_b    (csn_b),
    .i_wr_a     (wr_a),
    .i_wr_b     (wr_b),
    .i_be_a     (be_a),
    .i_be_b     (be_b),
    .i_addr_a   (addr_a),
    .i_addr_b   (addr_b),
    .i_data_a   (wdata_a),
    .i_data_b   (wdata_b),
    .o_data_a   (rdata_a),
    .o_data_b   (rdata_b),
    .o_rvalid_a (rvalid_a),
    .o_rvalid_b (rvalid_b),
    .o_ready    (ready),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] exp_q_a[$];
  logic [DW-1:0] exp_q_b[$];
  int            due_q_a[$];
  int            due_q_b[$];
  logic [DW-1:0] hold_a, hold_b;
  logic [DW-1:0] model [DEPTH];
  logic          model_ready;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus on both ports. If the model says the memory is
  // ready, reads take the pre-write model word, then B bytes, then A bytes
  // (A overrides B where both enable) are applied to the model.
  task automatic drive(input logic ca, input logic wa, input logic [3:0] bea,
                       input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic cb, input logic wb, input logic [3:0] beb,
                       input logic [AW-1:0] ab, input logic [DW-1:0] db);
    csn_a = ca; wr_a = wa; be_a = bea; addr_a = aa; wdata_a = da;
    csn_b = cb; wr_b = wb; be_b = beb; addr_b = ab; wdata_b = db;
    if (model_ready) begin
      if (!ca && !wa) begin exp_q_a.push_back(model[aa]); due_q_a.push_back(cyc + LAT); end
      if (!cb && !wb) begin exp_q_b.push_back(model[ab]); due_q_b.push_back(cyc + LAT); end
      if (!cb && wb)
        for (int n = 0; n < 4; n++) if (beb[n]) model[ab][8*n +: 8] = db[8*n +: 8];
      if (!ca && wa)
        for (int n = 0; n < 4; n++) if (bea[n]) model[aa][8*n +: 8] = da[8*n +: 8];
    end
    tick();
    csn_a = 1'b1;
    csn_b = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic rd_a(input logic [AW-1:0] a);
    drive(0, 0, 0, a, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic rd_b(input logic [AW-1:0] a);
    drive(1, 0, 0, 0, 0, 0, 0, 0, a, 0);
  endtask

  task automatic wr_a_t(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    drive(0, 1, be, a, d, 1, 0, 0, 0, 0);
  endtask

  task automatic random_access();
    drive(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          AW'($urandom_range(0, DEPTH - 1)), $urandom,
          logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          AW'($urandom_range(0, DEPTH - 1)), $urandom);
  endtask

  // Assert reset (dropping in-flight reads), check reset outputs, release
  // and verify o_ready rises exactly DEPTH edges later while accesses
  // issued during init are ignored.
  task automatic init_seq();
    rst = 1'b1;
    model_ready = 1'b0;
    exp_q_a.delete(); exp_q_b.delete(); due_q_a.delete(); due_q_b.delete();
    hold_a = '0; hold_b = '0;
    tick();
    check("rst_ready", {31'b0, ready}, 0);
    check("rst_rvalid_a", {31'b0, rvalid_a}, 0);
    check("rst_rvalid_b", {31'b0, rvalid_b}, 0);
    check("rst_data_a", rdata_a, 0);
    check("rst_data_b", rdata_b, 0);
    rst = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      random_access();
      check("ready_rise", {31'b0, ready}, (k == DEPTH) ? 32'd1 : 32'd0);
    end
    check("state_idle", {31'b0, dbg_state == ST_IDLE}, 1);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    model_ready = 1'b1;
  endtask

  // ---------------- monitor ----------------
  task automatic mon(input int p, input logic rv, input logic [DW-1:0] d);
    logic [DW-1:0] e;
    int            due;
    int            n;
    n = (p == 0) ? exp_q_a.size() : exp_q_b.size();
    if (rv) begin
      if (n == 0) begin
        check(p == 0 ? "unexpected_rvalid_a" : "unexpected_rvalid_b", {31'b0, rv}, 0);
      end else begin
        if (p == 0) begin e = exp_q_a.pop_front(); due = due_q_a.pop_front(); hold_a = e; end
        else        begin e = exp_q_b.pop_front(); due = due_q_b.pop_front(); hold_b = e; end
        check(p == 0 ? "read_data_a" : "read_data_b", d, e);
        check(p == 0 ? "latency_a" : "latency_b", cyc, due);
      end
    end else begin
      if (n > 0) begin
        due = (p == 0) ? due_q_a[0] : due_q_b[0];
        if (due <= cyc) begin
          check(p == 0 ? "missing_rvalid_a" : "missing_rvalid_b", {31'b0, rv}, 1);
          if (p == 0) begin void'(exp_q_a.pop_front()); void'(due_q_a.pop_front()); end
          else        begin void'(exp_q_b.pop_front()); void'(due_q_b.pop_front()); end
        end
      end
      check(p == 0 ? "hold_a" : "hold_b", d, (p == 0) ? hold_a : hold_b);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, rvalid_a, rdata_a);
      mon(1, rvalid_b, rdata_b);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    model_ready = 1'b0;
    hold_a = '0; hold_b = '0;
    csn_a = 1; csn_b = 1; wr_a = 0; wr_b = 0; be_a = 0; be_b = 0;
    addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
    tick();
    tick();
    check("por_ready", {31'b0, ready}, 0);
    check("por_data_a", rdata_a, 0);

    // First release, then a reset pulse 8 cycles into init.
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      random_access();
      check("ready_early", {31'b0, ready}, 0);
    end
    init_seq();

    // Every word reads zero after init.
    for (int a = 0; a < DEPTH; a++) drive(0, 0, 0, AW'(a), 0, 0, 0, 0, AW'(DEPTH - 1 - a), 0);
    idle(LAT + 1);

    // Byte-enabled partial write.
    wr_a_t(3, 32'hDEADBEEF, 4'b1111);
    wr_a_t(3, 32'h11223344, 4'b0101);
    rd_b(3);
    idle(LAT + 1);
    check("partial_write_model", model[3], 32'hDE22BE44);

    // Read-first across ports.
    drive(0, 1, 4'hF, 5, 32'hAAAAAAAA, 0, 0, 0, 5, 0);
    rd_b(5);
    idle(LAT + 1);

    // Same-address dual write.
    drive(0, 1, 4'b0001, 7, 32'h000000FF, 0, 1, 4'b1101, 7, 32'hFFFF0000);
    rd_a(7);
    idle(LAT + 1);
    check("collision_model", model[7], 32'hFFFF00FF);

    // Zero-enable write is a no-op; then data hold after a read.
    wr_a_t(9, 32'h00001234, 4'hF);
    drive(0, 1, 4'b0000, 9, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
    rd_a(9);
    idle(6);
    check("hold_1234", rdata_a, 32'h00001234);
    check("hold_rvalid", {31'b0, rvalid_a}, 0);

    // Random traffic with frequent address collisions.
    for (int i = 0; i < 400; i++) random_access();
    idle(LAT + 1);

    // Reset in IDLE with reads in flight: reads dropped, array re-cleared.
    drive(0, 0, 0, 3, 0, 0, 0, 0, 7, 0);
    init_seq();
    for (int a = 0; a < DEPTH; a++) drive(0, 0, 0, AW'(a), 0, 0, 0, 0, AW'(a), 0);
    idle(LAT + 2);

    check("drain_a", exp_q_a.size(), 0);
    check("drain_b", exp_q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpsram.md
DPSRAM -- requirements
Module: dpsram

Interface
REQ-001 Parameter DW, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter AW, default 10, address width; depth SHALL be 2**AW words.
REQ-003 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_csn_a / i_csn_b  input  1  chip select per port, 0 = active.
REQ-006 i_wr_a / i_wr_b  input  1  1 = write, 0 = read.
REQ-007 i_be_a / i_be_b  input  DW/8  byte write enables, bit n covers data bits [8n+7:8n].
REQ-008 i_addr_a / i_addr_b  input  AW  word address.
REQ-009 i_data_a / i_data_b  input  DW  write data.
REQ-010 o_data_a / o_data_b  output  DW  read data.
REQ-011 o_rvalid_a / o_rvalid_b  output  1  read data valid, one-cycle pulse per read.
REQ-012 o_ready  output  1  1 = init finished, accesses accepted.

Function
REQ-013 Two-state FSM: INIT, IDLE; INIT entered on reset.
REQ-014 INIT: 1 zero word per cycle at address counter 0..2**AW-1; o_ready=0; all port accesses ignored, no rvalid.
REQ-015 INIT->IDLE after address 2**AW-1 is written; o_ready=1 from next cycle, exactly 2**AW cycles after reset release.
REQ-016 IDLE: port access accepted when o_ready=1 and csn=0.
REQ-017 Read: o_data and o_rvalid valid 1 cycle after the request (base latency 1).
REQ-018 Outputs SHALL hold last read data when no read; never drive Z.
REQ-019 Write: only bytes with be=1 updated; be=0 write is a no-op (no rvalid).
REQ-020 Same-port or cross-port read of an address being written in the same cycle SHALL return old data (read-first).
REQ-021 Both ports write same address same cycle: bytes enabled on A take A data; bytes enabled only on B take B data.
REQ-022 Different addresses on A and B SHALL be fully independent, one access each per cycle.

Reset
REQ-023 Reset: o_data_a/b=0, o_rvalid_a/b=0, o_ready=0, FSM=INIT, init counter=0.
REQ-024 Reset asserted mid-INIT or mid-IDLE SHALL restart init from address 0; in-flight reads are dropped.
REQ-025 Memory array itself has no reset; cleared only by INIT.

Configuration
REQ-026 Macro DPSRAM_OREG_EN defined: extra output register stage per port, read latency 2, rvalid delayed to match, reset 0.
REQ-027 Macro undefined: read latency 1, no extra stage.

Structure
REQ-028 Package dpsram_pkg holds FSM state enum (INIT, IDLE) and read-latency constant (1 or 2 per DPSRAM_OREG_EN).
REQ-029 Sub-module dpsram_port (per-port read pipeline: data register, rvalid, optional OREG stage) instantiated twice.

Verification
REQ-030 Release reset, AW=4 -> o_ready rises exactly 16 cycles later; read of all 16 addresses returns 0.
REQ-031 A writes 0xDEADBEEF to addr 3 be=4'b1111, then A writes 0x11223344 addr 3 be=4'b0101 -> B read addr 3 returns 0xDE22BE44, rvalid 1 cycle later (2 with OREG).
REQ-032 A writes 0xAAAAAAAA to addr 5 while B reads addr 5 (old value 0) -> B returns 0; next B read returns 0xAAAAAAAA.
REQ-033 A writes 0x000000FF be=0001, B writes 0xFFFF0000 be=1101 same addr same cycle -> readback 0xFFFF00FF.
REQ-034 Accesses issued during INIT -> no rvalid, memory stays zero; reset pulse at cycle 8 of INIT -> o_ready rises 16 cycles after second release.
REQ-035 No reads after read of 0x1234 -> o_data holds 0x1234, rvalid stays 0.
